// File: rtl/varint_reader_if.sv
// DRAM read bus between the varint reader (master) and the DRAM model (slave).
//
// Handshake: the master pulses dram_en for exactly one cycle per request,
// with dram_addr valid in that same cycle. The slave later returns the bytes
// on dram_data, qualified per lane by dram_valid. There is no back-pressure:
// the master keeps waiting until every lane it asked for shows valid in one
// cycle. Valid bits the master is not waiting for are ignored.
interface varint_reader_if #(
  parameter int ADDR_W = 64,
  parameter int LANES  = 8
);
  logic [LANES-1:0]             dram_en;
  logic [LANES-1:0][ADDR_W-1:0] dram_addr;
  logic                         dram_rdwr;
  logic [LANES-1:0][7:0]        dram_data;
  logic [LANES-1:0]             dram_valid;

  modport master (
    output dram_en, dram_addr, dram_rdwr,
    input  dram_data, dram_valid
  );

  modport slave (
    input  dram_en, dram_addr, dram_rdwr,
    output dram_data, dram_valid
  );
endinterface

// File: rtl/varint_reader.sv
// Protobuf varint decoder with a DRAM read front end. Fetches up to ten bytes
// (one 8-lane read, then a 2-lane read if needed), assembles the 7-bit
// groups, applies the field-type post-processing and reports the length.
module varint_reader #(
  parameter int ADDR_W = 64,
  parameter int LANES  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [4:0]        field_type,
  varint_reader_if.master   dram,
  output logic [63:0]       value,
  output logic [3:0]        bytes_read,
  output logic              error,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ1  = 3'd1,
    WAIT1 = 3'd2,
    REQ2  = 3'd3,
    WAIT2 = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        type_q;
  logic [7:0][7:0]   buf_q;
  logic [63:0]       value_q;
  logic [3:0]        len_q;
  logic              err_q;

  logic              wait1_hit;
  logic              wait2_hit;
  logic              term_found;
  logic [2:0]        term_lane;
  logic [9:0][7:0]   bytes_c;
  logic [3:0]        len_c;
  logic              malformed_c;
  logic [63:0]       raw_c;
  logic [63:0]       proc_c;
  logic              type_err_c;
  logic [31:0]       z32;
  logic [31:0]       d32;

  assign wait1_hit = (state_q == WAIT1) && (dram.dram_valid == '1);
  assign wait2_hit = (state_q == WAIT2) && (dram.dram_valid[1:0] == 2'b11);

  // Terminating lane of the first read: lowest lane with a clear continuation bit.
  always_comb begin
    term_found = 1'b0;
    term_lane  = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (!dram.dram_data[k][7]) begin
        term_found = 1'b1;
        term_lane  = 3'(k);
      end
    end
  end

  // Assemble the byte window, its length and the raw 64-bit payload.
  always_comb begin
    bytes_c     = '0;
    len_c       = 4'd0;
    malformed_c = 1'b0;
    raw_c       = '0;
    if (state_q == WAIT2) begin
      bytes_c[7:0] = buf_q;
      bytes_c[8]   = dram.dram_data[0];
      bytes_c[9]   = dram.dram_data[1];
      if (!bytes_c[8][7]) begin
        len_c = 4'd9;
      end else begin
        len_c       = 4'd10;
        malformed_c = bytes_c[9][7];
      end
    end else begin
      bytes_c[7:0] = dram.dram_data;
      len_c        = {1'b0, term_lane} + 4'd1;
    end
    // Group 9 lands at bit 63; its upper payload bits shift out and are dropped.
    for (int k = 0; k < 10; k++) begin
      if (4'(k) < len_c) begin
        raw_c = raw_c | (64'(bytes_c[k][6:0]) << (7 * k));
      end
    end
  end

  // Field-type post-processing of the raw payload.
  always_comb begin
    proc_c     = raw_c;
    type_err_c = 1'b0;
    z32        = raw_c[31:0];
    d32        = (z32 >> 1) ^ (32'd0 - {31'd0, z32[0]});
    case (type_q)
      5'd3, 5'd4, 5'd14: proc_c = raw_c;
      5'd5:              proc_c = {{32{raw_c[31]}}, raw_c[31:0]};
      5'd13:             proc_c = {32'd0, raw_c[31:0]};
      5'd8:              proc_c = {63'd0, (raw_c != 64'd0)};
      5'd17:             proc_c = {{32{d32[31]}}, d32};
      5'd18:             proc_c = (raw_c >> 1) ^ (64'd0 - {63'd0, raw_c[0]});
      default: begin
        proc_c     = raw_c;
        type_err_c = 1'b1;
      end
    endcase
  end

  // Next state and DRAM request outputs.
  always_comb begin
    state_d        = state_q;
    dram.dram_en   = '0;
    dram.dram_addr = '0;
    case (state_q)
      IDLE: if (en) state_d = REQ1;
      REQ1: begin
        dram.dram_en = '1;
        for (int i = 0; i < LANES; i++) begin
          dram.dram_addr[i] = addr_q + ADDR_W'(i);
        end
        state_d = WAIT1;
      end
      WAIT1: if (wait1_hit) state_d = term_found ? DONE : REQ2;
      REQ2: begin
        dram.dram_en      = LANES'(2'b11);
        dram.dram_addr[0] = addr_q + ADDR_W'(8);
        dram.dram_addr[1] = addr_q + ADDR_W'(9);
        state_d           = WAIT2;
      end
      WAIT2: if (wait2_hit) state_d = DONE;
      DONE:  if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request latch, first-read buffer and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      type_q  <= '0;
      buf_q   <= '0;
      value_q <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && en) begin
        addr_q <= src_addr;
        type_q <= field_type;
      end
      if (wait1_hit) buf_q <= dram.dram_data;
      if ((wait1_hit && term_found) || wait2_hit) begin
        value_q <= proc_c;
        len_q   <= len_c;
        err_q   <= malformed_c | type_err_c;
      end
    end
  end

  assign dram.dram_rdwr = 1'b0;
  assign value          = value_q;
  assign bytes_read     = len_q;
  assign error          = err_q;
  assign done           = (state_q == DONE);
  assign dbg_state      = state_q;

endmodule

// File: doc/varint_reader.md
Name: varint_reader

Overview:
- Protobuf varint decoder with a DRAM read front end. It is the read-side counterpart of the varint writer used by the serializer.
- Given a source address and protobuf field type, it fetches up to 10 bytes over the 8-lane DRAM port and assembles the 7-bit groups into a 64-bit value.
- It applies type-specific post-processing (truncation, sign-extension, zigzag) and reports the number of bytes consumed.
- It sits in the deserializer datapath beside the DRAM model.

Parameters:
- ADDR_W, 64, DRAM byte-address width.
- LANES, 8, DRAM byte lanes per access; fixed at 8 for this design.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- en  input  1  start request; level, held high by the requester until done is seen.
- src_addr  input  64  address of the first varint byte; sampled when leaving IDLE.
- field_type  input  5  protobuf type code; sampled together with src_addr.
- dram_en  output  8  per-lane read enable; one-cycle pulse per request.
- dram_addr  output  8x64  per-lane byte address.
- dram_rdwr  output  1  held 0 (read) at all times.
- dram_data  input  8x8  per-lane read data.
- dram_valid  input  8  per-lane read-data valid.
- value  output  64  decoded value; valid while done=1.
- bytes_read  output  4  varint length in bytes (1..10); valid while done=1.
- error  output  1  malformed varint; valid while done=1.
- done  output  1  completion; held high until en drops.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: state=IDLE; dram_en=0; dram_addr=0; dram_rdwr=0; value=0; bytes_read=0; error=0; done=0. Assertion at any point aborts the decode with no further DRAM requests.
- States: IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE.
- IDLE: if en=1, latch src_addr and field_type; go to REQ1.
- REQ1 (1 cycle):
  - dram_en=8'hFF; dram_addr[i]=src+i.
  - Go to WAIT1. dram_en returns to 0 next cycle.
- WAIT1:
  - Wait for dram_valid[7:0]=8'hFF in one cycle, then capture dram_data.
  - Find t = lowest lane whose bit7=0.
  - If t exists: bytes_read=t+1; go to DONE.
  - Otherwise go to REQ2.
  - Unbounded wait; no timeout.
- REQ2 (1 cycle):
  - dram_en=8'b0000_0011; dram_addr[0]=src+8; dram_addr[1]=src+9.
  - All other dram_addr lanes drive 0.
- WAIT2:
  - Wait for dram_valid[1:0]=2'b11, then capture.
  - If byte8 bit7=0: bytes_read=9.
  - Else bytes_read=10; error=1 if byte9 bit7=1.
  - Go to DONE.
- Assembly: raw = OR over k<bytes_read of (byte[k] & 7'h7F) << 7k, truncated to 64 bits. Payload bits of byte9 above bit0 are discarded, not flagged.
- Type processing (applied to raw, then registered into value on entering DONE):
  - 3 int64, 4 uint64, 14 enum: value=raw.
  - 5 int32: value = sign-extend raw[31:0].
  - 13 uint32: value = zero-extend raw[31:0].
  - 8 bool: value = (raw!=0).
  - 17 sint32: z = raw[31:0]; value = sign-extend((z>>1) ^ -(z&1)) to 64 bits.
  - 18 sint64: value = (raw>>1) ^ -(raw[0]).
  - Any other code: value=raw and error=1.
- DONE: done=1 and outputs stable while en=1. When en=0, go to IDLE next cycle; done deasserts and value/bytes_read/error hold until the next start.
- en dropping before DONE: ignored; the decode completes and passes through DONE for one cycle.
- Address arithmetic wraps modulo 2^64.
- dram_valid outside the WAIT states is ignored.

Test Plan:
- Bytes 96 01 at 0x100, type 4, en=1 -> one 8-lane read at 0x100..0x107; value=150, bytes_read=2, error=0, done=1.
- Byte 00, type 13 -> value=0, bytes_read=1.
- FF FF FF FF 0F, type 5 -> value=FFFF_FFFF_FFFF_FFFF, bytes_read=5.
- Nine FF bytes then 01, type 3 -> second read with dram_en=0000_0011 at 0x108/0x109; value=FFFF_FFFF_FFFF_FFFF, bytes_read=10, error=0.
- Ten FF bytes -> bytes_read=10, error=1.
- Byte 03, type 18 -> value=FFFF_FFFF_FFFF_FFFE (-2).
- Byte 03, type 17 -> value=FFFF_FFFF_FFFF_FFFE (-2).
- Reset pulsed during WAIT1 -> all outputs 0, state IDLE. A valid arriving afterwards is ignored; the next en restarts cleanly.
